// File: rtl/mul_rs_if.sv
// Handshake/bus bundle between the issue stage, CDB, multiplier FU and the mul_rs.
interface mul_rs_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 4
);
  logic             issue_valid;
  logic             issue_ready;
  logic [W-1:0]     issue_vj;
  logic [W-1:0]     issue_vk;
  logic [TAG_W-1:0] issue_qj;
  logic [TAG_W-1:0] issue_qk;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [W-1:0]     cdb_data;
  logic             fu_en;
  logic [W-1:0]     fu_a;
  logic [W-1:0]     fu_b;
  logic             fu_finish;
  logic [W-1:0]     fu_res;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [W-1:0]     wb_data;
  logic             wb_grant;

  // Reservation station side
  modport slave (
    input  issue_valid, issue_vj, issue_vk, issue_qj, issue_qk, issue_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  fu_finish, fu_res, wb_grant,
    output issue_ready, fu_en, fu_a, fu_b, wb_valid, wb_tag, wb_data
  );

  // Environment side (issue stage, CDB, FU, arbiter)
  modport master (
    output issue_valid, issue_vj, issue_vk, issue_qj, issue_qk, issue_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output fu_finish, fu_res, wb_grant,
    input  issue_ready, fu_en, fu_a, fu_b, wb_valid, wb_tag, wb_data
  );
endinterface

// File: rtl/mul_rs.sv
// Multiplier reservation station: buffers issued ops, snoops the CDB, dispatches
// one ready op at a time to the FU and holds its result until the CDB grants it.
module mul_rs #(
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  mul_rs_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic             busy;
    logic [W-1:0]     vj;
    logic [W-1:0]     vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             r_ent [DEPTH];
  logic             r_fu_en;
  logic [W-1:0]     r_fu_a;
  logic [W-1:0]     r_fu_b;
  logic             r_fu_busy;
  logic [TAG_W-1:0] r_inflight_tag;
  logic             r_wb_valid;
  logic [TAG_W-1:0] r_wb_tag;
  logic [W-1:0]     r_wb_data;

  logic             w_has_free;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_has_rdy;
  logic [IDX_W-1:0] w_rdy_idx;
  logic             w_cdb_hit;
  logic             w_issue;
  logic             w_disp;
  ent_t             w_new;

  // Lowest-index free entry and lowest-index ready entry, from stored state only
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_has_rdy  = 1'b0;
    w_rdy_idx  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!r_ent[i].busy) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_ent[i].busy && (r_ent[i].qj == '0) && (r_ent[i].qk == '0)) begin
        w_has_rdy = 1'b1;
        w_rdy_idx = IDX_W'(i);
      end
    end
  end

  // Edge events and the incoming entry with same-edge CDB bypass applied
  always_comb begin
    w_cdb_hit = bus.cdb_valid && (bus.cdb_tag != '0);
    w_issue   = bus.issue_valid && w_has_free;
    w_disp    = !r_fu_busy && !r_wb_valid && w_has_rdy;
    w_new      = '0;
    w_new.busy = 1'b1;
    w_new.tag  = bus.issue_tag;
    if (w_cdb_hit && (bus.cdb_tag == bus.issue_qj)) begin
      w_new.vj = bus.cdb_data;
      w_new.qj = '0;
    end else begin
      w_new.vj = bus.issue_vj;
      w_new.qj = bus.issue_qj;
    end
    if (w_cdb_hit && (bus.cdb_tag == bus.issue_qk)) begin
      w_new.vk = bus.cdb_data;
      w_new.qk = '0;
    end else begin
      w_new.vk = bus.issue_vk;
      w_new.qk = bus.issue_qk;
    end
  end

  // Entry storage: issue into the free slot, snoop the CDB, free on dispatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_issue && (w_free_idx == IDX_W'(i))) begin
          r_ent[i] <= w_new;
        end else if (r_ent[i].busy) begin
          if (w_disp && (w_rdy_idx == IDX_W'(i))) begin
            r_ent[i].busy <= 1'b0;
          end
          if (w_cdb_hit && (r_ent[i].qj == bus.cdb_tag)) begin
            r_ent[i].vj <= bus.cdb_data;
            r_ent[i].qj <= '0;
          end
          if (w_cdb_hit && (r_ent[i].qk == bus.cdb_tag)) begin
            r_ent[i].vk <= bus.cdb_data;
            r_ent[i].qk <= '0;
          end
        end
      end
    end
  end

  // FU start pulse, operand registers and in-flight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fu_en        <= 1'b0;
      r_fu_a         <= '0;
      r_fu_b         <= '0;
      r_fu_busy      <= 1'b0;
      r_inflight_tag <= '0;
    end else begin
      r_fu_en <= w_disp;
      if (w_disp) begin
        r_fu_a         <= r_ent[w_rdy_idx].vj;
        r_fu_b         <= r_ent[w_rdy_idx].vk;
        r_inflight_tag <= r_ent[w_rdy_idx].tag;
        r_fu_busy      <= 1'b1;
      end else if (r_fu_busy && bus.fu_finish) begin
        r_fu_busy <= 1'b0;
      end
    end
  end

  // Writeback buffer: capture the FU result, hold it until granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
    end else if (r_fu_busy && bus.fu_finish) begin
      r_wb_valid <= 1'b1;
      r_wb_tag   <= r_inflight_tag;
      r_wb_data  <= bus.fu_res;
    end else if (r_wb_valid && bus.wb_grant) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign bus.issue_ready = w_has_free;
  assign bus.fu_en       = r_fu_en;
  assign bus.fu_a        = r_fu_a;
  assign bus.fu_b        = r_fu_b;
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_tag      = r_wb_tag;
  assign bus.wb_data     = r_wb_data;

endmodule

// File: tb/tb_mul_rs.sv
// Bench for mul_rs: directed scenarios followed by random traffic, all outputs
// compared each cycle against a transaction-level model of the station.
module tb_mul_rs;

  localparam int unsigned W     = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEPTH = 2;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mul_rs_if #(.W(W), .TAG_W(TAG_W)) bus ();

  mul_rs #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    bit               busy;
    logic [W-1:0]     vj;
    logic [W-1:0]     vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] tag;
  } m_ent_t;

  m_ent_t           m_e [DEPTH];
  bit               m_fu_en;
  logic [W-1:0]     m_fu_a;
  logic [W-1:0]     m_fu_b;
  bit               m_fu_busy;
  logic [TAG_W-1:0] m_infl;
  bit               m_wbv;
  logic [TAG_W-1:0] m_wbt;
  logic [W-1:0]     m_wbd;

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_e[i] = '{busy: 1'b0, vj: '0, vk: '0, qj: '0, qk: '0, tag: '0};
    end
    m_fu_en = 0; m_fu_a = '0; m_fu_b = '0; m_fu_busy = 0; m_infl = '0;
    m_wbv = 0; m_wbt = '0; m_wbd = '0;
  endtask

  function automatic bit model_ready();
    bit r;
    r = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (!m_e[i].busy) r = 1;
    return r;
  endfunction

  // One clock edge of the station, from the rules: pick free/ready slots,
  // broadcast, dispatch, complete, grant, then insert the new op.
  task automatic model_edge();
    m_ent_t nx [DEPTH];
    int     fi;
    int     ri;
    bit     hit;
    bit     comp;
    bit     grant;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fi = -1;
    ri = -1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!m_e[i].busy && fi < 0) fi = i;
      if (m_e[i].busy && m_e[i].qj == 0 && m_e[i].qk == 0 && ri < 0) ri = i;
    end
    hit   = bus.cdb_valid && (bus.cdb_tag != 0);
    comp  = m_fu_busy && bus.fu_finish;
    grant = m_wbv && bus.wb_grant;
    nx    = m_e;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (nx[i].busy && hit && nx[i].qj == bus.cdb_tag) begin nx[i].vj = bus.cdb_data; nx[i].qj = 0; end
      if (nx[i].busy && hit && nx[i].qk == bus.cdb_tag) begin nx[i].vk = bus.cdb_data; nx[i].qk = 0; end
    end
    m_fu_en = !m_fu_busy && !m_wbv && (ri >= 0);
    if (m_fu_en) begin
      m_fu_a = m_e[ri].vj;
      m_fu_b = m_e[ri].vk;
      m_infl = m_e[ri].tag;
      m_fu_busy = 1;
      nx[ri].busy = 0;
    end
    if (comp) begin
      m_wbv = 1; m_wbt = m_infl; m_wbd = bus.fu_res; m_fu_busy = 0;
    end else if (grant) begin
      m_wbv = 0;
    end
    if (bus.issue_valid && fi >= 0) begin
      nx[fi].busy = 1;
      nx[fi].tag  = bus.issue_tag;
      if (hit && bus.cdb_tag == bus.issue_qj) begin nx[fi].vj = bus.cdb_data; nx[fi].qj = 0; end
      else begin nx[fi].vj = bus.issue_vj; nx[fi].qj = bus.issue_qj; end
      if (hit && bus.cdb_tag == bus.issue_qk) begin nx[fi].vk = bus.cdb_data; nx[fi].qk = 0; end
      else begin nx[fi].vk = bus.issue_vk; nx[fi].qk = bus.issue_qk; end
    end
    m_e = nx;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("issue_ready", 64'(bus.issue_ready), 64'(model_ready()));
    chk("fu_en",       64'(bus.fu_en),       64'(m_fu_en));
    chk("fu_a",        64'(bus.fu_a),        64'(m_fu_a));
    chk("fu_b",        64'(bus.fu_b),        64'(m_fu_b));
    chk("wb_valid",    64'(bus.wb_valid),    64'(m_wbv));
    chk("wb_tag",      64'(bus.wb_tag),      64'(m_wbt));
    chk("wb_data",     64'(bus.wb_data),     64'(m_wbd));
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_vj = '0; bus.issue_vk = '0;
    bus.issue_qj = '0; bus.issue_qk = '0; bus.issue_tag = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.fu_finish = 0; bus.fu_res = '0; bus.wb_grant = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic issue(input logic [W-1:0] vj, input logic [W-1:0] vk,
                       input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                       input logic [TAG_W-1:0] tag);
    bus.issue_valid = 1; bus.issue_vj = vj; bus.issue_vk = vk;
    bus.issue_qj = qj; bus.issue_qk = qk; bus.issue_tag = tag;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [W-1:0] data);
    bus.cdb_valid = 1; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  // Finish the in-flight op and grant its result
  task automatic drain(input logic [W-1:0] res);
    idle(); bus.fu_finish = 1; bus.fu_res = res; cyc();
    idle(); bus.wb_grant = 1; cyc();
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    model_reset();
    #3;
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_fu_en",       64'(bus.fu_en),       64'd0);
    chk("rst_wb_valid",    64'(bus.wb_valid),    64'd0);
    chk("rst_wb_data",     64'(bus.wb_data),     64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ready op straight through
    issue(3, 5, 0, 0, 2); cyc();
    chk("t1_no_en_yet", 64'(bus.fu_en), 64'd0);
    idle(); cyc();
    chk("t1_fu_en", 64'(bus.fu_en), 64'd1);
    chk("t1_fu_a",  64'(bus.fu_a),  64'd3);
    chk("t1_fu_b",  64'(bus.fu_b),  64'd5);
    cyc();
    chk("t1_en_pulse", 64'(bus.fu_en), 64'd0);
    bus.fu_finish = 1; bus.fu_res = 15; cyc();
    idle(); cyc(); cyc();
    chk("t1_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_wb_tag",   64'(bus.wb_tag),   64'd2);
    chk("t1_wb_data",  64'(bus.wb_data),  64'd15);
    bus.wb_grant = 1; cyc();
    chk("t1_wb_clear", 64'(bus.wb_valid), 64'd0);
    idle();

    // Operand wait then CDB capture
    issue(0, 4, 3, 0, 1); cyc();
    idle(); cyc(); cyc();
    chk("t2_wait", 64'(bus.fu_en), 64'd0);
    cdb(3, 7); cyc();
    idle(); cyc();
    chk("t2_fu_en", 64'(bus.fu_en), 64'd1);
    chk("t2_fu_a",  64'(bus.fu_a),  64'd7);
    chk("t2_fu_b",  64'(bus.fu_b),  64'd4);
    drain(28);

    // Issue-time bypass
    issue(0, 2, 5, 0, 3); cdb(5, 9); cyc();
    idle(); cyc();
    chk("t3_fu_en", 64'(bus.fu_en), 64'd1);
    chk("t3_fu_a",  64'(bus.fu_a),  64'd9);
    drain(18);

    // Full station, ordering, writeback stall
    issue(0, 1, 6, 0, 4); cyc();
    issue(0, 2, 6, 0, 5); cyc();
    chk("t4_full", 64'(bus.issue_ready), 64'd0);
    issue(1, 1, 0, 0, 7); cyc();
    chk("t4_still_full", 64'(bus.issue_ready), 64'd0);
    idle(); cdb(6, 11); cyc();
    idle(); cyc();
    chk("t4_first_a", 64'(bus.fu_a), 64'd11);
    chk("t4_first_b", 64'(bus.fu_b), 64'd1);
    bus.fu_finish = 1; bus.fu_res = 11; cyc();
    idle(); cyc(); cyc();
    chk("t4_stall_en",  64'(bus.fu_en),  64'd0);
    chk("t4_stall_tag", 64'(bus.wb_tag), 64'd4);
    bus.wb_grant = 1; cyc();
    idle(); cyc();
    chk("t4_second_en", 64'(bus.fu_en), 64'd1);
    chk("t4_second_b",  64'(bus.fu_b),  64'd2);
    drain(22);

    // Reset mid-operation
    issue(1, 1, 0, 0, 9); cyc();
    issue(0, 1, 8, 0, 10); cyc();
    idle(); cyc();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_en",    64'(bus.fu_en),       64'd0);
    chk("t5_rst_wbv",   64'(bus.wb_valid),    64'd0);
    chk("t5_rst_ready", 64'(bus.issue_ready), 64'd1);
    cyc();
    rst_n = 1'b1;
    bus.fu_finish = 1; bus.fu_res = 99; cyc();
    idle(); cyc();
    chk("t5_no_wb",    64'(bus.wb_valid),    64'd0);
    chk("t5_ready",    64'(bus.issue_ready), 64'd1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_vj    = $urandom;
      bus.issue_vk    = $urandom;
      bus.issue_qj    = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : '0;
      bus.issue_qk    = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : '0;
      bus.issue_tag   = TAG_W'($urandom_range(1, 15));
      bus.cdb_valid   = ($urandom_range(0, 1) == 1);
      bus.cdb_tag     = TAG_W'($urandom_range(0, 7));
      bus.cdb_data    = $urandom;
      bus.fu_finish   = ($urandom_range(0, 2) == 0);
      bus.fu_res      = $urandom;
      bus.wb_grant    = ($urandom_range(0, 1) == 1);
      cyc();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
